// File: rtl/oc_desc_pkg.sv
// Shared constants for the AFU descriptor responder: descriptor word map, field values,
// error-source bit positions.
package oc_desc_pkg;

  localparam int unsigned NUM_ERR_SRC = 6;

  localparam int unsigned ERR_DESC_UNIMPL = 0;
  localparam int unsigned ERR_BAD_INDEX   = 1;
  localparam int unsigned ERR_VPD_UNIMPL  = 2;
  localparam int unsigned ERR_CFF_OVF     = 3;
  localparam int unsigned ERR_RFF_OVF     = 4;
  localparam int unsigned ERR_ERRVEC      = 5;

  // Descriptor word offsets (byte offset >> 2)
  localparam logic [4:0] WO_HDR          = 5'd0;   // 0x00 {16'h0, length}
  localparam logic [4:0] WO_NAME_FIRST   = 5'd1;   // 0x04..0x18 name space
  localparam logic [4:0] WO_VERSION      = 5'd7;   // 0x1C {afu_version, 16'h0}
  localparam logic [4:0] WO_CAPS         = 5'd8;   // 0x20 {profile, M1, C1}
  localparam logic [4:0] WO_GMMIO_OFF_LO = 5'd9;   // 0x24
  localparam logic [4:0] WO_GMMIO_OFF_HI = 5'd10;  // 0x28
  localparam logic [4:0] WO_GMMIO_SIZE   = 5'd11;  // 0x2C
  localparam logic [4:0] WO_PP_OFF_LO    = 5'd12;  // 0x30
  localparam logic [4:0] WO_PP_OFF_HI    = 5'd13;  // 0x34
  localparam logic [4:0] WO_PP_STRIDE    = 5'd14;  // 0x38
  localparam logic [4:0] WO_MEM_SIZE     = 5'd15;  // 0x3C
  localparam logic [4:0] WO_WWID_FIRST   = 5'd16;  // 0x40..0x4C

  localparam int unsigned LAST_DESC_OFFSET = 32'h4C;
  localparam int unsigned DESC_LEN_BYTES   = LAST_DESC_OFFSET + 4;

  localparam int unsigned NAME_WORDS = 6;
  localparam int unsigned NAME_BITS  = 32 * NAME_WORDS;
  localparam logic [NAME_BITS-1:0] NAME_SPACE = {"IBM,oc-accel", 96'h0};

  localparam logic [7:0] AFU_PROFILE = 8'h01;
  localparam logic       AFU_C1      = 1'b1;
  localparam logic       AFU_M1      = 1'b1;
  localparam logic [31:0] CAPS_WORD  = {16'h0000, AFU_PROFILE, 6'b0, AFU_M1, AFU_C1};

  // BAR0 in bits [2:0]; per-PASID area starts 2GB into BAR0
  localparam logic [31:0] GMMIO_OFF_LO_WORD = 32'h0000_0000;
  localparam logic [31:0] PP_OFF_LO_WORD    = 32'h8000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        bad_idx;
    logic        unimpl;
  } desc_stage_t;

  function automatic logic [31:0] name_word(input logic [4:0] i);
    logic [NAME_BITS-1:0] ns;
    ns = NAME_SPACE >> (32 * (NAME_WORDS - 1 - int'(i)));
    return ns[31:0];
  endfunction

endpackage

// File: rtl/oc_afu_desc_multi_if.sv
// Descriptor read request/response bundle between the cfg function block and the responder.
interface oc_afu_desc_multi_if;
  logic        cfg_desc_cmd_valid;
  logic [5:0]  cfg_desc_afu_index;
  logic [30:0] cfg_desc_offset;
  logic [31:0] desc_cfg_data;
  logic        desc_cfg_data_valid;
  logic        desc_cfg_echo_cmd_valid;

  modport master (
    output cfg_desc_cmd_valid, cfg_desc_afu_index, cfg_desc_offset,
    input  desc_cfg_data, desc_cfg_data_valid, desc_cfg_echo_cmd_valid
  );

  modport slave (
    input  cfg_desc_cmd_valid, cfg_desc_afu_index, cfg_desc_offset,
    output desc_cfg_data, desc_cfg_data_valid, desc_cfg_echo_cmd_valid
  );
endinterface

// File: rtl/oc_desc_word_mux.sv
// Combinational descriptor word lookup: (relative AFU index, byte offset) -> {data, unimpl}.
module oc_desc_word_mux
  import oc_desc_pkg::*;
#(
  parameter int unsigned NUM_AFUS     = 4,
  parameter logic [31:0] GMMIO_SIZE   = 32'h8000_0000,
  parameter logic [15:0] PASID_STRIDE = 16'h0040
) (
  input  logic [6:0]            rel_idx,
  input  logic                  bad_idx,
  input  logic [30:0]           offset,
  input  logic [16*NUM_AFUS-1:0] afu_version,
  output logic [31:0]           data,
  output logic                  unimpl
);

  logic [15:0] ver;
  logic [31:0] word;
  logic [4:0]  widx;

  assign widx = offset[6:2];

  always_comb begin
    ver = '0;
    for (int unsigned k = 0; k < NUM_AFUS; k++) begin
      if (rel_idx == 7'(k)) ver = afu_version[16*k +: 16];
    end

    unimpl = (offset[1:0] != 2'b00) || (offset > 31'(LAST_DESC_OFFSET));

    word = '0;
    if (widx >= WO_NAME_FIRST && widx < WO_NAME_FIRST + 5'(NAME_WORDS)) begin
      word = name_word(widx - WO_NAME_FIRST);
    end else begin
      case (widx)
        WO_HDR:          word = {16'h0000, 16'(DESC_LEN_BYTES)};
        WO_VERSION:      word = {ver, 16'h0000};
        WO_CAPS:         word = CAPS_WORD;
        WO_GMMIO_OFF_LO: word = GMMIO_OFF_LO_WORD;
        WO_GMMIO_SIZE:   word = GMMIO_SIZE;
        WO_PP_OFF_LO:    word = PP_OFF_LO_WORD;
        WO_PP_STRIDE:    word = {PASID_STRIDE, 16'h0000};
        default:         word = '0;  // high offsets, memory size and WWID are all zero
      endcase
    end

    data = (unimpl || bad_idx) ? '0 : word;
  end

endmodule

// File: rtl/oc_afu_desc_multi.sv
// Multi-AFU descriptor table responder: fixed-latency read pipeline, echo and sticky error log.
// Define OC_DESC_ERRCNT_EN to build the six saturating per-source error counters.
module oc_afu_desc_multi
  import oc_desc_pkg::*;
#(
  parameter int unsigned NUM_AFUS        = 4,
  parameter int unsigned FIRST_AFU_INDEX = 0,
  parameter int unsigned RESP_LATENCY    = 2,
  parameter logic [31:0] GMMIO_SIZE      = 32'h8000_0000,
  parameter logic [15:0] PASID_STRIDE    = 16'h0040
) (
  input  logic                   clock_tlx,
  input  logic                   reset_n,
  oc_afu_desc_multi_if.slave     cfg,
  input  logic [16*NUM_AFUS-1:0] afu_version,
  input  logic                   vpd_err_unimplemented_addr,
  input  logic                   cfg0_cff_fifo_overflow,
  input  logic                   cfg0_rff_fifo_overflow,
  input  logic [127:0]           cfg_errvec,
  input  logic                   cfg_errvec_valid,
  input  logic                   err_clear,
  output logic                   err_unimplemented_addr,
  output logic [5:0]             err_status,
  output logic [127:0]           err_first_vec,
  output logic [95:0]            err_count
);

  localparam int unsigned LAST = RESP_LATENCY - 1;

  logic [6:0]  rel_idx;
  logic        bad_idx;
  logic [31:0] mux_data;
  logic        mux_unimpl;
  logic        echo_q;

  desc_stage_t pipe_d [RESP_LATENCY];
  desc_stage_t pipe_q [RESP_LATENCY];

  logic [NUM_ERR_SRC-1:0] src_ev;
  logic [NUM_ERR_SRC-1:0] status_d, status_q;
  logic [127:0]           first_vec_d, first_vec_q;

  assign rel_idx = {1'b0, cfg.cfg_desc_afu_index} - 7'(FIRST_AFU_INDEX);
  assign bad_idx = ({1'b0, cfg.cfg_desc_afu_index} < 7'(FIRST_AFU_INDEX)) ||
                   (rel_idx >= 7'(NUM_AFUS));

  oc_desc_word_mux #(
    .NUM_AFUS     (NUM_AFUS),
    .GMMIO_SIZE   (GMMIO_SIZE),
    .PASID_STRIDE (PASID_STRIDE)
  ) u_word_mux (
    .rel_idx     (rel_idx),
    .bad_idx     (bad_idx),
    .offset      (cfg.cfg_desc_offset),
    .afu_version (afu_version),
    .data        (mux_data),
    .unimpl      (mux_unimpl)
  );

  always_comb begin
    pipe_d[0].valid   = cfg.cfg_desc_cmd_valid;
    pipe_d[0].data    = cfg.cfg_desc_cmd_valid ? mux_data : '0;
    pipe_d[0].bad_idx = cfg.cfg_desc_cmd_valid & bad_idx;
    pipe_d[0].unimpl  = cfg.cfg_desc_cmd_valid & mux_unimpl;
    for (int i = 1; i < RESP_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Descriptor errors are logged on the edge that presents the response.
  always_comb begin
    src_ev                  = '0;
    src_ev[ERR_DESC_UNIMPL] = pipe_d[LAST].unimpl;
    src_ev[ERR_BAD_INDEX]   = pipe_d[LAST].bad_idx;
    src_ev[ERR_VPD_UNIMPL]  = vpd_err_unimplemented_addr;
    src_ev[ERR_CFF_OVF]     = cfg0_cff_fifo_overflow;
    src_ev[ERR_RFF_OVF]     = cfg0_rff_fifo_overflow;
    src_ev[ERR_ERRVEC]      = cfg_errvec_valid & (|cfg_errvec);
  end

  always_comb begin
    status_d    = (err_clear ? '0 : status_q) | src_ev;
    first_vec_d = err_clear ? '0 : first_vec_q;
    if (src_ev[ERR_ERRVEC] && (!status_q[ERR_ERRVEC] || err_clear)) first_vec_d = cfg_errvec;
  end

  always_ff @(posedge clock_tlx or negedge reset_n) begin
    if (!reset_n) begin
      echo_q <= 1'b0;
      for (int i = 0; i < RESP_LATENCY; i++) pipe_q[i] <= '0;
      status_q    <= '0;
      first_vec_q <= '0;
    end else begin
      echo_q <= cfg.cfg_desc_cmd_valid;
      for (int i = 0; i < RESP_LATENCY; i++) pipe_q[i] <= pipe_d[i];
      status_q    <= status_d;
      first_vec_q <= first_vec_d;
    end
  end

  assign cfg.desc_cfg_echo_cmd_valid = echo_q;
  assign cfg.desc_cfg_data_valid     = pipe_q[LAST].valid;
  assign cfg.desc_cfg_data           = pipe_q[LAST].data;
  assign err_unimplemented_addr      = pipe_q[LAST].bad_idx | pipe_q[LAST].unimpl;
  assign err_status                  = status_q;
  assign err_first_vec               = first_vec_q;

`ifdef OC_DESC_ERRCNT_EN
  logic [NUM_ERR_SRC-1:0][15:0] cnt_d, cnt_q;

  always_comb begin
    for (int n = 0; n < NUM_ERR_SRC; n++) begin
      cnt_d[n] = err_clear ? 16'h0000 : cnt_q[n];
      if (src_ev[n] && cnt_d[n] != 16'hFFFF) cnt_d[n] = cnt_d[n] + 16'd1;
    end
  end

  always_ff @(posedge clock_tlx or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_oc_afu_desc_multi.sv
// Self-checking bench for oc_afu_desc_multi (NUM_AFUS=4, FIRST_AFU_INDEX=8, RESP_LATENCY=2).
module tb_oc_afu_desc_multi;

  localparam int unsigned NA    = 4;
  localparam int unsigned FIRST = 8;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0]  vers = 64'hA1B2_C3D4_E5F6_1728;
  logic         vpd, cff, rff, evv, clr;
  logic [127:0] vec;
  logic         err_unimpl;
  logic [5:0]   err_status;
  logic [127:0] err_first_vec;
  logic [95:0]  err_count;

  oc_afu_desc_multi_if dif ();

  oc_afu_desc_multi #(
    .NUM_AFUS        (NA),
    .FIRST_AFU_INDEX (FIRST),
    .RESP_LATENCY    (LAT)
  ) dut (
    .clock_tlx                  (clk),
    .reset_n                    (rst_n),
    .cfg                        (dif),
    .afu_version                (vers),
    .vpd_err_unimplemented_addr (vpd),
    .cfg0_cff_fifo_overflow     (cff),
    .cfg0_rff_fifo_overflow     (rff),
    .cfg_errvec                 (vec),
    .cfg_errvec_valid           (evv),
    .err_clear                  (clr),
    .err_unimplemented_addr     (err_unimpl),
    .err_status                 (err_status),
    .err_first_vec              (err_first_vec),
    .err_count                  (err_count)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic        err;
    logic        bad;
    logic        unimpl;
  } exp_t;

  typedef struct {
    logic [5:0]  idx;
    logic [30:0] off;
    logic [31:0] data;
    logic        err;
  } vec_t;

  int unsigned tests = 0;
  int unsigned failed = 0;
  int unsigned cyc = 0;
  exp_t q[$];

  // Reference state and the inputs applied before the last edge
  logic [5:0]   m_status;
  logic [127:0] m_vec;
  int unsigned  m_cnt[6];
  logic         p_cmd, p_vpd, p_cff, p_rff, p_evv, p_clr;
  logic [127:0] p_vec;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_bad(input logic [5:0] idx);
    return (int'(idx) < int'(FIRST)) || (int'(idx) >= int'(FIRST + NA));
  endfunction

  function automatic logic model_unimpl(input logic [30:0] off);
    return (off % 4 != 0) || (off > 31'h4C);
  endfunction

  // Builds the descriptor image byte by byte and reads a big-endian word from it
  function automatic logic [31:0] model_word(input logic [5:0] idx, input logic [30:0] off);
    byte unsigned img [80];
    string        name;
    logic [63:0]  v;
    int           rel, a;
    if (model_bad(idx) || model_unimpl(off)) return 32'h0;
    v = vers;
    rel = int'(idx) - int'(FIRST);
    name = "IBM,oc-accel";
    foreach (img[i]) img[i] = 8'h00;
    img[3] = 8'h50;
    for (int i = 0; i < name.len(); i++) img[4+i] = name[i];
    img[28] = v[16*rel+8 +: 8];
    img[29] = v[16*rel +: 8];
    img[34] = 8'h01;
    img[35] = 8'h03;
    img[44] = 8'h80;
    img[48] = 8'h80;
    img[57] = 8'h40;
    a = int'(off);
    return {img[a], img[a+1], img[a+2], img[a+3]};
  endfunction

  function automatic logic [95:0] exp_count();
    logic [95:0] r = '0;
`ifdef OC_DESC_ERRCNT_EN
    for (int n = 0; n < 6; n++) r[16*n +: 16] = 16'(m_cnt[n]);
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_status = '0;
    m_vec = '0;
    for (int n = 0; n < 6; n++) m_cnt[n] = 0;
    {p_cmd, p_vpd, p_cff, p_rff, p_evv, p_clr} = '0;
    p_vec = '0;
    q.delete();
  endtask

  // One clock: observe the previous edge, then drive inputs for the next one.
  task automatic step(input logic cmd, input logic [5:0] idx, input logic [30:0] off,
                      input logic [2:0] src, input logic ev_valid, input logic [127:0] ev_vec,
                      input logic clear, input logic use_tab, input logic [31:0] tab_data,
                      input logic tab_err);
    exp_t       e;
    logic [5:0] ev;
    logic       dv;
    @(negedge clk);
    cyc++;
    e = '{due: 0, data: '0, err: 1'b0, bad: 1'b0, unimpl: 1'b0};
    dv = 1'b0;
    ev = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      dv = 1'b1;
      ev[0] = e.unimpl;
      ev[1] = e.bad;
    end
    ev[2] = p_vpd;
    ev[3] = p_cff;
    ev[4] = p_rff;
    ev[5] = p_evv && (p_vec != '0);
    if (ev[5] && (!m_status[5] || p_clr)) m_vec = p_vec;
    else if (p_clr) m_vec = '0;
    if (p_clr) begin
      m_status = '0;
      for (int n = 0; n < 6; n++) m_cnt[n] = 0;
    end
    m_status |= ev;
    for (int n = 0; n < 6; n++) if (ev[n] && m_cnt[n] < 65535) m_cnt[n]++;

    check("echo", 128'(dif.desc_cfg_echo_cmd_valid), 128'(p_cmd));
    check("data_valid", 128'(dif.desc_cfg_data_valid), 128'(dv));
    if (dv) check("data", 128'(dif.desc_cfg_data), 128'(e.data));
    check("err_unimpl", 128'(err_unimpl), 128'(dv & e.err));
    check("err_status", 128'(err_status), 128'(m_status));
    check("err_first_vec", err_first_vec, m_vec);
    check("err_count", 128'(err_count), 128'(exp_count()));

    dif.cfg_desc_cmd_valid = cmd;
    dif.cfg_desc_afu_index = idx;
    dif.cfg_desc_offset    = off;
    {rff, cff, vpd} = src;
    evv = ev_valid;
    vec = ev_vec;
    clr = clear;
    {p_rff, p_cff, p_vpd} = src;
    p_cmd = cmd;
    p_evv = ev_valid;
    p_vec = ev_vec;
    p_clr = clear;
    if (cmd) begin
      e.due    = cyc + LAT;
      e.bad    = model_bad(idx);
      e.unimpl = model_unimpl(off);
      e.data   = use_tab ? tab_data : model_word(idx, off);
      e.err    = use_tab ? tab_err : (e.bad | e.unimpl);
      q.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 31'd0, 3'b000, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [5:0] idx, input logic [30:0] off);
    step(1'b1, idx, off, 3'b000, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  vec_t         tab[$];
  logic [127:0] va, vb;
  logic [30:0]  roff;
  int unsigned  r;

  initial begin
    dif.cfg_desc_cmd_valid = 1'b0;
    dif.cfg_desc_afu_index = '0;
    dif.cfg_desc_offset    = '0;
    {vpd, cff, rff, evv, clr} = '0;
    vec = '0;
    model_reset();

    tab.push_back('{6'd9,  31'h04, 32'h4942_4D2C, 1'b0});  // "IBM,"
    tab.push_back('{6'd8,  31'h08, 32'h6F63_2D61, 1'b0});  // "oc-a"
    tab.push_back('{6'd11, 31'h0C, 32'h6363_656C, 1'b0});  // "ccel"
    tab.push_back('{6'd10, 31'h10, 32'h0000_0000, 1'b0});
    tab.push_back('{6'd8,  31'h00, 32'h0000_0050, 1'b0});
    tab.push_back('{6'd9,  31'h1C, 32'hE5F6_0000, 1'b0});
    tab.push_back('{6'd10, 31'h20, 32'h0000_0103, 1'b0});
    tab.push_back('{6'd11, 31'h2C, 32'h8000_0000, 1'b0});
    tab.push_back('{6'd8,  31'h30, 32'h8000_0000, 1'b0});
    tab.push_back('{6'd9,  31'h38, 32'h0040_0000, 1'b0});
    tab.push_back('{6'd10, 31'h4C, 32'h0000_0000, 1'b0});
    tab.push_back('{6'd12, 31'h04, 32'h0000_0000, 1'b1});
    tab.push_back('{6'd9,  31'h06, 32'h0000_0000, 1'b1});
    tab.push_back('{6'd7,  31'h04, 32'h0000_0000, 1'b1});
    tab.push_back('{6'd8,  31'h50, 32'h0000_0000, 1'b1});

    #1;
    check("rst_data_valid", 128'(dif.desc_cfg_data_valid), 128'(0));
    check("rst_echo", 128'(dif.desc_cfg_echo_cmd_valid), 128'(0));
    check("rst_data", 128'(dif.desc_cfg_data), 128'(0));
    check("rst_status", 128'(err_status), 128'(0));
    check("rst_count", 128'(err_count), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[i]) begin
      step(1'b1, tab[i].idx, tab[i].off, 3'b000, 1'b0, '0, 1'b0, 1'b1, tab[i].data, tab[i].err);
      idle();
      idle();
    end
    check("tab_status", 128'(err_status), 128'(6'b000011));

    // Back-to-back version reads of every AFU
    for (int k = 0; k < 4; k++)
      step(1'b1, 6'(FIRST + k), 31'h1C, 3'b000, 1'b0, '0, 1'b0, 1'b1,
           {vers[16*k +: 16], 16'h0000}, 1'b0);
    repeat (3) idle();

    // First-vector capture, then clear racing a new overflow
    step(1'b0, 6'd0, 31'd0, 3'b000, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    va = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    vb = ~va;
    step(1'b0, 6'd0, 31'd0, 3'b000, 1'b1, va, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 6'd0, 31'd0, 3'b000, 1'b1, vb, 1'b0, 1'b0, '0, 1'b0);
    idle();
    check("first_vec_a", err_first_vec, va);
    step(1'b0, 6'd0, 31'd0, 3'b010, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle();
    check("clear_vs_cff", 128'(err_status), 128'(6'b001000));

    for (int n = 0; n < 800; n++) begin
      r = $urandom % 10;
      if (r < 7)       roff = 31'(4 * ($urandom % 20));
      else if (r == 7) roff = 31'(4 * ($urandom % 20) + 1 + $urandom % 3);
      else if (r == 8) roff = 31'($urandom);
      else             roff = 31'(32'h50 + 4 * ($urandom % 8));
      step(1'($urandom % 2), 6'(6 + $urandom % 8), roff,
           3'(($urandom % 16 == 0) ? (1 << ($urandom % 3)) : 0),
           1'($urandom % 8 == 0), ($urandom % 4 == 0) ? 128'h0
                                  : {$urandom, $urandom, $urandom, $urandom},
           1'($urandom % 32 == 0), 1'b0, '0, 1'b0);
    end
    repeat (3) idle();

    // Reset with two reads in flight
    step(1'b0, 6'd0, 31'd0, 3'b011, 1'b1, 128'h5, 1'b0, 1'b0, '0, 1'b0);
    rd(6'd9, 31'h04);
    rd(6'd10, 31'h1C);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data_valid", 128'(dif.desc_cfg_data_valid), 128'(0));
    check("mid_rst_echo", 128'(dif.desc_cfg_echo_cmd_valid), 128'(0));
    check("mid_rst_data", 128'(dif.desc_cfg_data), 128'(0));
    check("mid_rst_status", 128'(err_status), 128'(0));
    check("mid_rst_vec", err_first_vec, 128'(0));
    check("mid_rst_count", 128'(err_count), 128'(0));
    dif.cfg_desc_cmd_valid = 1'b0;
    {vpd, cff, rff, evv, clr} = '0;
    vec = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) idle();

    // Counter saturation on the rff source
`ifdef OC_DESC_ERRCNT_EN
    repeat (65540) step(1'b0, 6'd0, 31'd0, 3'b100, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle();
    check("rff_cnt_sat", 128'(err_count[79:64]), 128'(16'hFFFF));
    step(1'b0, 6'd0, 31'd0, 3'b100, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle();
    check("rff_cnt_clear_inc", 128'(err_count[79:64]), 128'(16'h0001));
`else
    repeat (10) step(1'b0, 6'd0, 31'd0, 3'b100, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle();
    check("cnt_tied_off", 128'(err_count), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
